// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR bank: maximal-length XNOR tap masks and lockup state.
package lfsr_pkg;

    typedef logic [31:0] lfsr_word_t;

    // Bit k of the mask selects state bit k+1 in 1-based tap numbering.
    function automatic lfsr_word_t taps(input int num_bits);
        case (num_bits)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // All-ones is the state an XNOR LFSR can never leave.
    function automatic lfsr_word_t lockup_state(input int num_bits);
        if (num_bits >= 32)
            return 32'hFFFF_FFFF;
        return (32'd1 << num_bits) - 32'd1;
    endfunction

endpackage

// File: rtl/lfsr_leap_step.sv
// Combinational leap-ahead: advances one XNOR Fibonacci LFSR by STEP shifts.
module lfsr_leap_step
    import lfsr_pkg::*;
#(
    parameter int NUM_BITS = 8,
    parameter int STEP     = 1
)(
    input  logic [NUM_BITS-1:0] state_in,
    output logic [NUM_BITS-1:0] state_out
);

    localparam lfsr_word_t          TAP_W = taps(NUM_BITS);
    localparam logic [NUM_BITS-1:0] TAP_M = TAP_W[NUM_BITS-1:0];

    // Every tap set has an even count, so the XNOR chain is the reduction XNOR.
    always_comb begin
        logic [NUM_BITS-1:0] s;
        s = state_in;
        for (int i = 0; i < STEP; i++)
            s = {s[NUM_BITS-2:0], ~^(s & TAP_M)};
        state_out = s;
    end

endmodule

// File: rtl/lfsr_bank.sv
// Multi-channel leap-ahead XNOR LFSR bank with per-channel runtime seeds and a
// valid/ready output stream.
module lfsr_bank
    import lfsr_pkg::*;
#(
    parameter int                  NUM_BITS = 8,
    parameter int                  NUM_CH   = 4,
    parameter int                  STEP     = 1,
    parameter logic [NUM_BITS-1:0] RST_SEED = {{(NUM_BITS-1){1'b0}}, 1'b1}
)(
    input  logic                                              i_Clk,
    input  logic                                              i_Rst_n,
    input  logic                                              i_Enable,
    input  logic                                              i_Seed_DV,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]    i_Seed_Ch,
    input  logic [NUM_BITS-1:0]                               i_Seed_Data,
    output logic                                              o_Seed_Err,
    output logic                                              o_Valid,
    input  logic                                              i_Ready,
    output logic [NUM_CH*NUM_BITS-1:0]                        o_Data,
    output logic [NUM_CH-1:0]                                 o_Wrap,
    output logic [NUM_BITS-1:0]                               o_Period_Cnt
);

    localparam int                  CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam lfsr_word_t          LOCK_W = lockup_state(NUM_BITS);
    localparam logic [NUM_BITS-1:0] LOCKUP = LOCK_W[NUM_BITS-1:0];

    logic                fire_p0;
    logic                seed_err_p0;
    logic                seed_ok_p0;
    logic                vld_p1;
    logic                err_p1;
    logic [NUM_BITS-1:0] cnt_p1;

    assign fire_p0     = vld_p1 & i_Ready;
    assign seed_err_p0 = i_Seed_DV & ((i_Seed_Data == LOCKUP) |
                                      (32'(i_Seed_Ch) >= 32'(NUM_CH)));
    assign seed_ok_p0  = i_Seed_DV & ~seed_err_p0;

    // p0 -> p1: per-channel state, stored seed and wrap flag
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [CH_W-1:0] IDX = CH_W'(g);

        logic [NUM_BITS-1:0] state_p1;
        logic [NUM_BITS-1:0] seed_p1;
        logic [NUM_BITS-1:0] adv_p0;
        logic                wrap_p1;
        logic                load_p0;

        assign load_p0 = seed_ok_p0 & (i_Seed_Ch == IDX);

        lfsr_leap_step #(
            .NUM_BITS (NUM_BITS),
            .STEP     (STEP)
        ) u_step (
            .state_in  (state_p1),
            .state_out (adv_p0)
        );

        always_ff @(posedge i_Clk or negedge i_Rst_n) begin
            if (!i_Rst_n) begin
                state_p1 <= RST_SEED;
                seed_p1  <= RST_SEED;
                wrap_p1  <= 1'b0;
            end else begin
                wrap_p1 <= fire_p0 & ~load_p0 & (adv_p0 == seed_p1);
                if (load_p0) begin
                    state_p1 <= i_Seed_Data;
                    seed_p1  <= i_Seed_Data;
                end else if (fire_p0) begin
                    state_p1 <= adv_p0;
                end
            end
        end

        assign o_Data[g*NUM_BITS +: NUM_BITS] = state_p1;
        assign o_Wrap[g]                      = wrap_p1;
    end

    // p0 -> p1: stream control and period counter
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
            cnt_p1 <= '0;
        end else begin
            vld_p1 <= i_Enable & ~seed_ok_p0;
            err_p1 <= seed_err_p0;
            if (seed_ok_p0 && (i_Seed_Ch == '0))
                cnt_p1 <= '0;
            else if (fire_p0)
                cnt_p1 <= cnt_p1 + 1'b1;
        end
    end

    assign o_Valid      = vld_p1;
    assign o_Seed_Err   = err_p1;
    assign o_Period_Cnt = cnt_p1;

endmodule
